// File: rtl/enc_pkg.sv
// Shared types and helpers for the encryption address sequencer and its
// multiply-accumulate datapath.
package enc_pkg;

  typedef enum logic {
    MODE_CYCLIC     = 1'b0,
    MODE_NEGACYCLIC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit width for a count of 'value' items, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/enc_loop_counter.sv
// One level of the address loop nest: counts 0, STEP, 2*STEP ... up to
// MAX-STEP, then wraps to 0. 'wrap' flags the top value so the next level can chain on it.
module enc_loop_counter
  import enc_pkg::*;
#(
  parameter int MAX  = 2,
  parameter int STEP = 1,
  parameter int W    = clog2_min1(MAX)
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  assign wrap = (count == W'(MAX - STEP));

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = wrap ? '0 : count + W'(STEP);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/enc_addr_sequencer.sv
// Walks k x a-index x s-index and presents registered A/s/b/e addresses plus
// per-lane negate flags, one LANES-wide beat per valid/ready handshake.
module enc_addr_sequencer
  import enc_pkg::*;
#(
  parameter int N     = 64,
  parameter int K     = 8,
  parameter int LANES = 2,
  localparam int NW   = $clog2(N),
  localparam int KW   = clog2_min1(K),
  localparam int AW   = $clog2(K * N),
  localparam int SW   = clog2_min1(K * N / LANES),
  localparam int EW   = clog2_min1(N / LANES)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_in,
  input  logic                mode_in,
  input  logic                abort_in,
  input  logic                ready_in,
  output logic                valid_out,
  output logic                last_out,
  output logic [KW-1:0]       k_out,
  output logic [NW-1:0]       a_idx_out,
  output logic [NW-1:0]       s_base_out,
  output logic [AW-1:0]       A_addr,
  output logic [SW-1:0]       s_addr,
  output logic [EW-1:0]       e_addr,
  output logic [LANES*NW-1:0] b_addr,
  output logic [LANES-1:0]    negate_out,
  output logic                e_first_out,
  output logic                busy_out,
  output logic                done_out
);

  localparam int LG = $clog2(LANES);

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;

  logic          hs, run_clear, s_en, a_en, k_en;
  logic          s_wrap, a_wrap, k_wrap;
  logic [NW-1:0] s_nx, a_nx;
  logic [KW-1:0] k_nx;

  assign hs = valid_out & ready_in;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    run_clear = 1'b0;
    s_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d   = RUN;
          mode_d    = mode_e'(mode_in);
          run_clear = 1'b1;
        end
      end
      RUN: begin
        // Abort outranks a handshake in the same cycle.
        if (abort_in) begin
          state_d   = IDLE;
          run_clear = 1'b1;
        end else if (hs) begin
          s_en = 1'b1;
          if (k_wrap && a_wrap && s_wrap) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign a_en = s_en & s_wrap;
  assign k_en = a_en & a_wrap;

  // The counters are the beat state; they wrap back to 0 after the final beat.
  enc_loop_counter #(.MAX(N), .STEP(LANES), .W(NW)) u_s_cnt (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .clear      (run_clear),
    .enable     (s_en),
    .count      (s_base_out),
    .count_next (s_nx),
    .wrap       (s_wrap)
  );

  enc_loop_counter #(.MAX(N), .STEP(1), .W(NW)) u_a_cnt (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .clear      (run_clear),
    .enable     (a_en),
    .count      (a_idx_out),
    .count_next (a_nx),
    .wrap       (a_wrap)
  );

  enc_loop_counter #(.MAX(K), .STEP(1), .W(KW)) u_k_cnt (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .clear      (run_clear),
    .enable     (k_en),
    .count      (k_out),
    .count_next (k_nx),
    .wrap       (k_wrap)
  );

  // Address fields are computed from the counters' next values so the
  // registered outputs line up with the counter registers on the same beat.
  logic                valid_d, last_d, e_first_d, done_d;
  logic [AW-1:0]       a_addr_d;
  logic [SW-1:0]       s_addr_d;
  logic [EW-1:0]       e_addr_d;
  logic [LANES*NW-1:0] b_addr_d;
  logic [LANES-1:0]    negate_d;
  logic [NW:0]         lane_sum;

  always_comb begin
    valid_d   = (state_d == RUN);
    done_d    = (state_d == DONE);
    last_d    = 1'b0;
    e_first_d = 1'b0;
    a_addr_d  = '0;
    s_addr_d  = '0;
    e_addr_d  = '0;
    b_addr_d  = '0;
    negate_d  = '0;
    lane_sum  = '0;
    if (valid_d) begin
      last_d    = (k_nx == KW'(K - 1)) && (a_nx == NW'(N - 1)) && (s_nx == NW'(N - LANES));
      e_first_d = (k_nx == '0) && (a_nx == '0);
      a_addr_d  = AW'(int'(k_nx) * N + int'(a_nx));
      s_addr_d  = SW'(int'(k_nx) * (N / LANES) + int'(s_nx >> LG));
      e_addr_d  = EW'(s_nx >> LG);
      for (int l = 0; l < LANES; l++) begin
        // a + s_base + l < 2N, so one conditional subtract reduces mod N.
        lane_sum = {1'b0, a_nx} + {1'b0, s_nx} + (NW + 1)'(l);
        if (lane_sum >= (NW + 1)'(N)) begin
          lane_sum    = lane_sum - (NW + 1)'(N);
          negate_d[l] = (mode_d == MODE_NEGACYCLIC);
        end
        b_addr_d[l*NW +: NW] = lane_sum[NW-1:0];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      mode_q      <= MODE_CYCLIC;
      valid_out   <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      last_out    <= 1'b0;
      e_first_out <= 1'b0;
      A_addr      <= '0;
      s_addr      <= '0;
      e_addr      <= '0;
      b_addr      <= '0;
      negate_out  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      valid_out   <= valid_d;
      busy_out    <= valid_d;
      done_out    <= done_d;
      last_out    <= last_d;
      e_first_out <= e_first_d;
      A_addr      <= a_addr_d;
      s_addr      <= s_addr_d;
      e_addr      <= e_addr_d;
      b_addr      <= b_addr_d;
      negate_out  <= negate_d;
    end
  end

endmodule

// File: tb/tb_enc_addr_sequencer.sv
// Self-checking bench: scoreboarded full runs on an N=8/K=2/LANES=2 instance
// and a vector table on an N=4/K=1/LANES=4 instance.
module tb_enc_addr_sequencer;

  localparam int N = 8;
  localparam int K = 2;
  localparam int L = 2;
  localparam int BEATS = K * N * N / L;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic start_in = 1'b0, mode_in = 1'b0, abort_in = 1'b0, ready_in = 1'b0;
  logic valid_out, last_out, e_first_out, busy_out, done_out;
  logic [0:0] k_out;
  logic [2:0] a_idx_out, s_base_out, s_addr;
  logic [3:0] A_addr;
  logic [1:0] e_addr, negate_out;
  logic [5:0] b_addr;

  logic start_2 = 1'b0, mode_2 = 1'b0, abort_2 = 1'b0, ready_2 = 1'b0;
  logic valid_2, last_2, e_first_2, busy_2, done_2;
  logic [0:0] k_2, s_addr_2, e_addr_2;
  logic [1:0] a_idx_2, s_base_2, A_addr_2;
  logic [7:0] b_addr_2;
  logic [3:0] negate_2;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] sb_q[$];

  always #5 clk_in = ~clk_in;

  enc_addr_sequencer #(.N(N), .K(K), .LANES(L)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .mode_in(mode_in),
    .abort_in(abort_in), .ready_in(ready_in), .valid_out(valid_out), .last_out(last_out),
    .k_out(k_out), .a_idx_out(a_idx_out), .s_base_out(s_base_out), .A_addr(A_addr),
    .s_addr(s_addr), .e_addr(e_addr), .b_addr(b_addr), .negate_out(negate_out),
    .e_first_out(e_first_out), .busy_out(busy_out), .done_out(done_out)
  );

  enc_addr_sequencer #(.N(4), .K(1), .LANES(4)) dut2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_2), .mode_in(mode_2),
    .abort_in(abort_2), .ready_in(ready_2), .valid_out(valid_2), .last_out(last_2),
    .k_out(k_2), .a_idx_out(a_idx_2), .s_base_out(s_base_2), .A_addr(A_addr_2),
    .s_addr(s_addr_2), .e_addr(e_addr_2), .b_addr(b_addr_2), .negate_out(negate_2),
    .e_first_out(e_first_2), .busy_out(busy_2), .done_out(done_2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] act1();
    return 64'({last_out, k_out, a_idx_out, s_base_out, A_addr, s_addr, e_addr,
                b_addr, negate_out, e_first_out});
  endfunction

  // Reference beat i of a run, derived with plain modulo arithmetic.
  function automatic logic [63:0] exp1(input int i, input bit m);
    int s, a, k, t;
    logic [2:0] b0, b1;
    logic n0, n1;
    logic [25:0] v;
    s = (i % (N / L)) * L;
    a = (i / (N / L)) % N;
    k = i / (N * N / L);
    t = a + s;
    b0 = 3'(t % N);
    n0 = m && (t >= N);
    t = a + s + 1;
    b1 = 3'(t % N);
    n1 = m && (t >= N);
    v = {(i == BEATS - 1), 1'(k), 3'(a), 3'(s), 4'(k * N + a), 3'(k * (N / L) + s / L),
         2'(s / L), b1, b0, n1, n0, (k == 0 && a == 0)};
    return 64'(v);
  endfunction

  task automatic do_run(input bit mode, input int stall_beat, input int start_beat,
                        input int abort_beat, input int reset_beat, input bit start_abort);
    int beats, cyc, stall_cnt;
    bit aborted, was_reset;
    logic [63:0] popped;
    beats = 0; cyc = 0; stall_cnt = 0; aborted = 0; was_reset = 0;
    sb_q.delete();
    for (int i = 0; i < BEATS; i++) sb_q.push_back(exp1(i, mode));
    @(negedge clk_in);
    start_in = 1'b1; mode_in = mode; abort_in = start_abort; ready_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b0; abort_in = 1'b0;
    while (beats < BEATS && !aborted && !was_reset && cyc < 500) begin
      if (beats == reset_beat) begin
        rst_n_in = 1'b0;
        #1;
        check("reset_mid_outs", act1(), 64'd0);
        check("reset_mid_flags", {valid_out, busy_out, done_out}, 64'd0);
        #1 rst_n_in = 1'b1;
        ready_in = 1'b0;
        was_reset = 1;
      end else begin
        check("valid_busy", {valid_out, busy_out, done_out}, 64'b110);
        check("beat", act1(), sb_q[0]);
        if (mode && beats == 0) begin
          check("beat0_A", A_addr, 64'd0);
          check("beat0_b", b_addr, 64'b001_000);
          check("beat0_efirst", e_first_out, 64'd1);
        end
        if (mode && beats == BEATS - 1) begin
          check("final_A", A_addr, 64'd15);
          check("final_s", s_addr, 64'd7);
          check("final_b", b_addr, 64'b110_101);
          check("final_neg", negate_out, 64'b11);
          check("final_last", last_out, 64'd1);
        end
        ready_in = !(beats == stall_beat && stall_cnt < 5);
        if (!ready_in) stall_cnt++;
        start_in = (beats == start_beat);
        mode_in = (beats == start_beat) ? !mode : mode;
        abort_in = (beats == abort_beat);
        if (abort_in) aborted = 1;
        else if (ready_in) begin
          popped = sb_q.pop_front();
          beats++;
        end
        @(negedge clk_in);
        cyc++;
        start_in = 1'b0; abort_in = 1'b0; ready_in = 1'b0;
      end
    end
    check("run_bound", (cyc < 500), 64'd1);
    if (aborted) begin
      check("abort_flags", {valid_out, busy_out, done_out}, 64'd0);
    end else if (!was_reset) begin
      check("beat_count", beats, BEATS);
      check("done_pulse", {valid_out, busy_out, done_out, last_out}, 64'b0010);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      check("done_clear", {valid_out, busy_out, done_out}, 64'd0);
    end
  endtask

  typedef struct {
    logic       ready;
    logic [2:0] flags;  // {valid, done, last}
    logic [1:0] a;
    logic [7:0] b;
    logic [3:0] neg;
    logic       ef;
  } vec2_t;

  vec2_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 3'b100, 2'd0, 8'hE4, 4'b0000, 1'b1};
    tbl[1] = '{1'b0, 3'b100, 2'd1, 8'h39, 4'b1000, 1'b0};
    tbl[2] = '{1'b1, 3'b100, 2'd1, 8'h39, 4'b1000, 1'b0};
    tbl[3] = '{1'b1, 3'b100, 2'd2, 8'h4E, 4'b1100, 1'b0};
    tbl[4] = '{1'b1, 3'b101, 2'd3, 8'h93, 4'b1110, 1'b0};
    tbl[5] = '{1'b0, 3'b010, 2'd0, 8'h00, 4'b0000, 1'b0};
    tbl[6] = '{1'b0, 3'b000, 2'd0, 8'h00, 4'b0000, 1'b0};

    repeat (2) @(negedge clk_in);
    check("reset_outs", act1(), 64'd0);
    check("reset_flags", {valid_out, busy_out, done_out}, 64'd0);
    check("reset_dut2", {valid_2, busy_2, done_2, b_addr_2}, 64'd0);
    rst_n_in = 1'b1;

    @(negedge clk_in);
    abort_in = 1'b1;
    @(negedge clk_in);
    abort_in = 1'b0;
    check("idle_abort", {valid_out, busy_out, done_out}, 64'd0);

    do_run(1'b1, -1, -1, -1, -1, 1'b0);
    do_run(1'b0, -1, -1, -1, -1, 1'b0);
    do_run(1'b1, 10, 30, -1, -1, 1'b0);
    do_run(1'b0, -1, -1, 40, -1, 1'b0);
    do_run(1'b1, -1, -1, -1, -1, 1'b1);
    do_run(1'b1, -1, -1, -1, 20, 1'b0);
    do_run(1'b1, -1, -1, -1, -1, 1'b0);

    @(negedge clk_in);
    start_2 = 1'b1; mode_2 = 1'b1;
    @(negedge clk_in);
    start_2 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("t2_flags", {valid_2, done_2, last_2}, tbl[i].flags);
      if (tbl[i].flags[2])
        check("t2_beat", {a_idx_2, b_addr_2, negate_2, e_first_2},
              {tbl[i].a, tbl[i].b, tbl[i].neg, tbl[i].ef});
      ready_2 = tbl[i].ready;
      @(negedge clk_in);
    end
    ready_2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
